// File: rtl/soc_data_mem_pipelined.sv
// Word-addressed on-chip data memory with per-byte writes and a 1- or 2-stage read pipeline.
// An optional zero-fill sweep runs after reset, and out-of-range accesses raise a sticky flag.
module soc_data_mem_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int DEPTH          = 342,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done,
  output logic                    range_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {RESET_HOLD, CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;
  logic                    rdv_q;
  logic                    in_range;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;

  assign in_range    = {1'b0, address} < DEPTH_L;
  assign accept      = (state == READY) && clken && chipselect && (read || write);
  assign wr_acc      = accept && write;
  assign rd_acc      = accept && read && !write;
  assign waitrequest = (state != READY) || !clken;
  // A stalled pipeline keeps its valid bit but must not present it until clken returns.
  assign readdatavalid = rdv_q && clken;

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[address[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_HOLD;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (clken) begin
      case (state)
        RESET_HOLD: begin
          cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state <= CLEAR;
          end else begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_WORD) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM; zero-fill comes from the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state == CLEAR) begin
        mem[cnt[IDX_W-1:0]] <= '0;
      end else if (wr_acc && in_range) begin
        for (int b = 0; b < BYTES; b++) begin
          if (byteenable[b]) mem[address[IDX_W-1:0]][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      rdv_q       <= 1'b0;
      readdata    <= '0;
      range_error <= 1'b0;
    end else if (clken) begin
      if (accept && !in_range) range_error <= 1'b1;
      if (READ_LATENCY == 1) begin
        rdv_q <= rd_acc;
        if (rd_acc) readdata <= rd_word;
      end else begin
        s1_valid <= rd_acc;
        if (rd_acc) s1_data <= rd_word;
        rdv_q <= s1_valid;
        if (s1_valid) readdata <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_soc_data_mem_pipelined.sv
// Directed bench: two instances (read latency 1 and 2) share one bus and are
// checked against hand-computed values for clear, byte enables, latency, range and stall.
module tb_soc_data_mem_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [8:0]  address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;

  logic [31:0] readdata,  readdata2;
  logic        readdatavalid, readdatavalid2;
  logic        waitrequest, waitrequest2;
  logic        init_done, init_done2;
  logic        range_error, range_error2;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  soc_data_mem_pipelined #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .init_done(init_done), .range_error(range_error)
  );

  soc_data_mem_pipelined #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata2), .readdatavalid(readdatavalid2),
    .waitrequest(waitrequest2), .init_done(init_done2), .range_error(range_error2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one bus cycle, waits for the edge that samples it, then returns the bus to idle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [8:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
    chipselect = 1'b1;
    read       = rd;
    write      = wr;
    address    = addr;
    byteenable = be;
    writedata  = wd;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic waitInit(input string tag);
    int  cycles  = 0;
    bit  wr_drop = 0;
    while (!init_done && cycles < 2000) begin
      tick();
      cycles++;
      if (!init_done && !waitrequest) wr_drop = 1;
    end
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'd343);
    checkOutput({tag, "_wr_high"}, 32'(wr_drop), 32'd0);
    checkOutput({tag, "_wr_ready"}, 32'(waitrequest), 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [8:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0);
    checkOutput({tag, "_rdv"}, 32'(readdatavalid), 32'd1);
    checkOutput({tag, "_data"}, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    clken      = 1'b1;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    repeat (3) tick();

    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_rdv", 32'(readdatavalid), 32'd0);
    checkOutput("rst_wr", 32'(waitrequest), 32'd1);
    checkOutput("rst_init", 32'(init_done), 32'd0);
    checkOutput("rst_range", 32'(range_error), 32'd0);

    reset_n = 1'b1;
    waitInit("clear1");

    // Seed nonzero data so the later clear has something to erase.
    applyStimulus(1'b0, 1'b1, 9'd0,   4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 9'd170, 4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 9'd341, 4'hF, 32'hDEADBEEF);
    readCheck("seed170", 9'd170, 32'hDEADBEEF);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (101) tick();
    checkOutput("midclr_init", 32'(init_done), 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_wr", 32'(waitrequest), 32'd1);
    checkOutput("midrst_init", 32'(init_done), 32'd0);
    tick();
    reset_n = 1'b1;
    waitInit("clear2");

    readCheck("clr0",   9'd0,   32'h0);
    readCheck("clr170", 9'd170, 32'h0);
    readCheck("clr341", 9'd341, 32'h0);

    applyStimulus(1'b0, 1'b1, 9'd5, 4'b1111, 32'hA5A5A5A5);
    applyStimulus(1'b0, 1'b1, 9'd5, 4'b0010, 32'h0000FF00);
    readCheck("be_merge", 9'd5, 32'hA5A5FFA5);
    applyStimulus(1'b0, 1'b1, 9'd5, 4'b0000, 32'h00000000);
    readCheck("be_none", 9'd5, 32'hA5A5FFA5);
    applyStimulus(1'b1, 1'b1, 9'd5, 4'b1000, 32'h11000000);
    checkOutput("rdwr_norv", 32'(readdatavalid), 32'd0);
    readCheck("rdwr_write", 9'd5, 32'h11A5FFA5);

    applyStimulus(1'b0, 1'b1, 9'd1, 4'hF, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 9'd2, 4'hF, 32'h22222222);
    applyStimulus(1'b0, 1'b1, 9'd3, 4'hF, 32'h33333333);
    applyStimulus(1'b1, 1'b0, 9'd1, 4'h0, 32'h0);
    checkOutput("l1_c1_data", readdata, 32'h11111111);
    checkOutput("l2_c1_rdv", 32'(readdatavalid2), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'd2, 4'h0, 32'h0);
    checkOutput("l1_c2_data", readdata, 32'h22222222);
    checkOutput("l2_c2_rdv", 32'(readdatavalid2), 32'd1);
    checkOutput("l2_c2_data", readdata2, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 9'd3, 4'h0, 32'h0);
    checkOutput("l1_c3_data", readdata, 32'h33333333);
    checkOutput("l2_c3_rdv", 32'(readdatavalid2), 32'd1);
    checkOutput("l2_c3_data", readdata2, 32'h22222222);
    tick();
    checkOutput("l1_c4_rdv", 32'(readdatavalid), 32'd0);
    checkOutput("l1_c4_hold", readdata, 32'h33333333);
    checkOutput("l2_c4_rdv", 32'(readdatavalid2), 32'd1);
    checkOutput("l2_c4_data", readdata2, 32'h33333333);
    tick();
    checkOutput("l2_c5_rdv", 32'(readdatavalid2), 32'd0);
    checkOutput("l2_c5_hold", readdata2, 32'h33333333);

    checkOutput("range_pre", 32'(range_error), 32'd0);
    applyStimulus(1'b0, 1'b1, 9'd400, 4'hF, 32'h12345678);
    checkOutput("range_set", 32'(range_error), 32'd1);
    readCheck("range_rd400", 9'd400, 32'h0);
    readCheck("range_alias58", 9'd58, 32'h0);
    readCheck("range_alias144", 9'd144, 32'h0);
    checkOutput("range_sticky", 32'(range_error), 32'd1);

    applyStimulus(1'b0, 1'b1, 9'd7, 4'hF, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 9'd7, 4'h0, 32'h0);
    clken = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall%0d_rdv", i), 32'(readdatavalid), 32'd0);
      checkOutput($sformatf("stall%0d_wr", i), 32'(waitrequest), 32'd1);
      if (i < 2) tick();
    end
    tick();
    clken = 1'b1;
    #1;
    checkOutput("stall_rdv", 32'(readdatavalid), 32'd1);
    checkOutput("stall_data", readdata, 32'hCAFEF00D);
    checkOutput("stall_l2_wait", 32'(readdatavalid2), 32'd0);
    tick();
    checkOutput("stall_rdv_drop", 32'(readdatavalid), 32'd0);
    checkOutput("stall_l2_rdv", 32'(readdatavalid2), 32'd1);
    checkOutput("stall_l2_data", readdata2, 32'hCAFEF00D);

    applyStimulus(1'b1, 1'b0, 9'd7, 4'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("inflight_rdv", 32'(readdatavalid2), 32'd0);
    checkOutput("inflight_data", readdata2, 32'h0);
    checkOutput("inflight_range", 32'(range_error), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("inflight_after", 32'(readdatavalid2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/soc_data_mem_pipelined.md
SOC_DATA_MEM_PIPELINED -- requirements
Module: soc_data_mem_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word-address width.
REQ-003 SHALL have parameter DEPTH, default 342, number of implemented words, with DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, accepted read to readdatavalid in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill memory after reset, 0 = contents undefined.
REQ-006 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-008 SHALL have port chipselect, input, 1 bit, slave select.
REQ-009 SHALL have port address, input, ADDR_WIDTH bits, word address.
REQ-010 SHALL have port byteenable, input, DATA_WIDTH/8 bits, per-byte write enable.
REQ-011 SHALL have port read, input, 1 bit, read request.
REQ-012 SHALL have port write, input, 1 bit, write request.
REQ-013 SHALL have port writedata, input, DATA_WIDTH bits, write data.
REQ-014 SHALL have port clken, input, 1 bit, clock enable for the whole block.
REQ-015 SHALL have port readdata, output, DATA_WIDTH bits, registered read data.
REQ-016 SHALL have port readdatavalid, output, 1 bit, qualifies readdata for one cycle.
REQ-017 SHALL have port waitrequest, output, 1 bit, when high no request is accepted.
REQ-018 SHALL have port init_done, output, 1 bit, high once the memory is usable.
REQ-019 SHALL have port range_error, output, 1 bit, sticky out-of-range access flag.

Function
REQ-020 SHALL implement an FSM with states RESET_HOLD, CLEAR and READY; RESET_HOLD is occupied while reset_n is low.
REQ-021 SHALL, on reset_n release, go to CLEAR if CLEAR_ON_RESET=1, otherwise go to READY on the first clken-high edge.
REQ-022 SHALL, in CLEAR, write zero to word cnt on each clken-high cycle, with cnt running 0..DEPTH-1, and go to READY after word DEPTH-1 is written (DEPTH cycles).
REQ-023 SHALL drive waitrequest high in RESET_HOLD and CLEAR, and whenever clken=0.
REQ-024 SHALL drive init_done low in RESET_HOLD and CLEAR, and high in READY (first READY cycle).
REQ-025 SHALL accept a request when state=READY, clken=1, chipselect=1 and (read or write) are all true.
REQ-026 SHALL, on an accepted write, update only the bytes whose byteenable bit is 1; byteenable=0 leaves the word unchanged.
REQ-027 SHALL treat read and write asserted in the same cycle as a write only, with no readdatavalid.
REQ-028 SHALL, for an accepted read, assert readdatavalid with data exactly READ_LATENCY clken-high cycles later; one read per cycle is sustained, back-to-back, in order.
REQ-029 SHALL, for a read of an address written in the same cycle, return the old data.
REQ-030 SHALL, for address >= DEPTH, ignore writes, return zero for reads (readdatavalid still asserted), and set range_error.
REQ-031 SHALL keep range_error set until reset.
REQ-032 SHALL, while clken=0, freeze all state, counters and pipeline stages, force readdatavalid low, and hold readdata; pending reads emerge after clken returns, each taking its remaining latency.
REQ-033 SHALL hold readdata at its last value when readdatavalid=0.

Reset
REQ-034 SHALL, while reset_n is low, drive readdata=0, readdatavalid=0, waitrequest=1, init_done=0, range_error=0, and discard pipeline contents.
REQ-035 SHALL, on reset assertion during CLEAR, restart clearing from word 0 on release; reads in flight at reset produce no readdatavalid.

Verification
REQ-036 SHALL verify clear: CLEAR_ON_RESET=1, DEPTH=342, release reset -> waitrequest high for 342 cycles, init_done high on cycle 343, reads of words 0, 170 and 341 return 0.
REQ-037 SHALL verify byte enables: write 0xA5A5A5A5 to word 5 with be=1111, then 0x0000FF00 with be=0010 -> read of word 5 returns 0xA5A5FFA5.
REQ-038 SHALL verify latency: READ_LATENCY=2, reads of words 1, 2, 3 back-to-back -> readdatavalid high on cycles +2, +3, +4 with the data in order.
REQ-039 SHALL verify range: write 0x12345678 to address 400 -> range_error=1, a read of address 400 returns 0, and word 400 mod 512 (400) is unchanged and not aliased into 0..341.
REQ-040 SHALL verify clken: clken=0 for 3 cycles after a read is accepted with READ_LATENCY=1 -> readdatavalid appears on the first cycle after clken returns high, with waitrequest high throughout the stall.
REQ-041 SHALL verify reset mid-clear: reset_n pulsed low at clear count 100 -> the full 342-cycle clear reruns and init_done stays low until it completes.
